// File: rtl/fp_final_pipe_if.sv
// Handshake and data bundle for the FP final pack/exception stage.
// The slave modport is the pipe's view; the master modport is the producer/consumer side.
interface fp_final_pipe_if #(
    parameter int WEXP  = 8,
    parameter int WFRAC = 23
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WFRAC-1:0]      a_frac;
    logic [WFRAC-1:0]      b_frac;
    logic                  sa;
    logic                  sb;
    logic                  abig;
    logic                  ainf;
    logic                  binf;
    logic                  anan;
    logic                  bnan;
    logic                  asignan;
    logic                  bsignan;
    logic                  denorm;
    logic                  inex;
    logic                  expneg;
    logic [WEXP:0]         exp;
    logic                  effop;
    logic                  op;
    logic                  zero;
    logic [WFRAC-1:0]      roundsum;
    logic [1:0]            rmode;
    logic                  overtrap;
    logic                  undertrap;
    logic                  out_valid;
    logic                  out_ready;
    logic [WEXP+WFRAC:0]   result;
    logic [3:0]            out_flags;
    logic [3:0]            sticky_flags;
    logic                  flag_clear;
    logic                  trap_pulse;

    modport master (
        output in_valid, a_frac, b_frac, sa, sb, abig, ainf, binf, anan, bnan,
               asignan, bsignan, denorm, inex, expneg, exp, effop, op, zero,
               roundsum, rmode, overtrap, undertrap, out_ready, flag_clear,
        input  in_ready, out_valid, result, out_flags, sticky_flags, trap_pulse
    );

    modport slave (
        input  in_valid, a_frac, b_frac, sa, sb, abig, ainf, binf, anan, bnan,
               asignan, bsignan, denorm, inex, expneg, exp, effop, op, zero,
               roundsum, rmode, overtrap, undertrap, out_ready, flag_clear,
        output in_ready, out_valid, result, out_flags, sticky_flags, trap_pulse
    );
endinterface

// File: rtl/fp_final_pipe.sv
// Two-stage pipelined IEEE-754 special-case resolution, packing and exception flagging
// for the FP adder, with valid/ready backpressure, sticky status and a trap pulse.
module fp_final_pipe #(
    parameter int WEXP  = 8,
    parameter int WFRAC = 23
) (
    input  logic            clk,
    input  logic            rst_n,
    fp_final_pipe_if.slave  bus
);

    // Trapped results are rebiased: overflow subtracts 3*2^(WEXP-2), which mod 2^WEXP is +2^(WEXP-2).
    localparam logic [WEXP-1:0] OVF_ADJ   = WEXP'(1 << (WEXP - 2));
    localparam logic [WEXP-1:0] UNF_ADJ   = WEXP'(3 << (WEXP - 2));
    localparam logic [WEXP-1:0] EXP_MAXFN = {{(WEXP-1){1'b1}}, 1'b0};
    localparam logic [WFRAC-1:0] QNAN_BIT = {1'b1, {(WFRAC-1){1'b0}}};

    logic w_s1Adv;
    logic w_s2Adv;
    logic w_outXfer;

    logic w_specInput;
    logic w_overflow;
    logic w_underflow;
    logic w_invalid;
    logic w_inexact;
    logic w_signMux;
    logic w_finalSign;

    logic                 r_s1Valid;
    logic [WFRAC-1:0]     r_s1AFrac;
    logic [WFRAC-1:0]     r_s1BFrac;
    logic                 r_s1ANan;
    logic                 r_s1BNan;
    logic                 r_s1Spec;
    logic                 r_s1Ovf;
    logic                 r_s1Unf;
    logic                 r_s1Inv;
    logic                 r_s1Inx;
    logic                 r_s1Sign;
    logic                 r_s1Zero;
    logic                 r_s1Denorm;
    logic [WEXP-1:0]      r_s1Exp;
    logic [WFRAC-1:0]     r_s1Round;
    logic [1:0]           r_s1Rmode;
    logic                 r_s1OvTrap;
    logic                 r_s1UnTrap;

    logic w_rp;
    logic w_rz;
    logic w_rm;
    logic w_clamp;
    logic w_ovfTrapped;
    logic w_trap;
    logic [WEXP-1:0]  w_biasExp;
    logic [WFRAC-1:0] w_nanFrac;
    logic [WEXP-1:0]  w_expOut;
    logic [WFRAC-1:0] w_fracOut;

    logic                 r_s2Valid;
    logic [WEXP+WFRAC:0]  r_result;
    logic [3:0]           r_flags;
    logic                 r_s2Trap;
    logic [3:0]           r_sticky;
    logic                 r_trapPulse;

    assign w_s2Adv   = ~r_s2Valid | bus.out_ready;
    assign w_s1Adv   = ~r_s1Valid | w_s2Adv;
    assign w_outXfer = r_s2Valid & bus.out_ready;

    assign w_specInput = bus.ainf | bus.binf | bus.anan | bus.bnan;
    assign w_overflow  = (bus.exp[WEXP] | (&bus.exp[WEXP-1:0])) & ~bus.expneg
                         & ~w_specInput & ~bus.zero;
    assign w_underflow = bus.expneg & (bus.inex | bus.undertrap);
    assign w_invalid   = (bus.ainf & bus.binf & bus.effop) | bus.asignan | bus.bsignan;
    assign w_inexact   = (bus.inex | (w_overflow & ~bus.overtrap)) & ~w_specInput;
    assign w_signMux   = bus.zero ? (bus.sa & bus.sb & ~bus.op)
                                  : ((bus.abig & bus.sa) | ((bus.sb ^ bus.op) & (~bus.abig | bus.sa)));
    assign w_finalSign = (bus.zero & (bus.rmode == 2'b11) & (bus.sa ^ bus.sb)) | w_signMux;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1Valid <= 1'b0;
        end else if (w_s1Adv) begin
            r_s1Valid <= bus.in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_s1Adv && bus.in_valid) begin
            r_s1AFrac  <= bus.a_frac;
            r_s1BFrac  <= bus.b_frac;
            r_s1ANan   <= bus.anan;
            r_s1BNan   <= bus.bnan;
            r_s1Spec   <= w_specInput;
            r_s1Ovf    <= w_overflow;
            r_s1Unf    <= w_underflow;
            r_s1Inv    <= w_invalid;
            r_s1Inx    <= w_inexact;
            r_s1Sign   <= w_finalSign;
            r_s1Zero   <= bus.zero;
            r_s1Denorm <= bus.denorm;
            r_s1Exp    <= bus.exp[WEXP-1:0];
            r_s1Round  <= bus.roundsum;
            r_s1Rmode  <= bus.rmode;
            r_s1OvTrap <= bus.overtrap;
            r_s1UnTrap <= bus.undertrap;
        end
    end

    assign w_rz         = (r_s1Rmode == 2'b01);
    assign w_rp         = (r_s1Rmode == 2'b10);
    assign w_rm         = (r_s1Rmode == 2'b11);
    assign w_clamp      = r_s1Ovf & (w_rz | (w_rp & r_s1Sign) | (w_rm & ~r_s1Sign));
    assign w_ovfTrapped = r_s1Ovf & r_s1OvTrap;
    assign w_biasExp    = r_s1Exp + (w_ovfTrapped ? OVF_ADJ : UNF_ADJ);
    assign w_trap       = w_ovfTrapped | (r_s1Unf & r_s1UnTrap) | r_s1Inv;
    // Forcing the MSB keeps the NaN quiet while the rest of the payload comes from the NaN operand.
    assign w_nanFrac    = (r_s1ANan ? r_s1AFrac : r_s1BFrac) | QNAN_BIT;

    always_comb begin
        w_expOut = r_s1Exp;
        if (w_ovfTrapped || ((r_s1Unf || r_s1Denorm) && r_s1UnTrap)) begin
            w_expOut = w_biasExp;
        end else if (r_s1Spec || r_s1Ovf || r_s1Unf || r_s1Zero || r_s1Denorm) begin
            if ((r_s1Unf || r_s1Zero || r_s1Denorm) && !r_s1Inv) begin
                w_expOut = '0;
            end else if (w_clamp) begin
                w_expOut = EXP_MAXFN;
            end else begin
                w_expOut = '1;
            end
        end
    end

    always_comb begin
        w_fracOut = r_s1Round;
        if (r_s1Spec || r_s1Ovf || r_s1Unf || r_s1Inv) begin
            if (r_s1ANan || r_s1BNan || r_s1Inv) begin
                w_fracOut = w_nanFrac;
            end else if (w_clamp) begin
                w_fracOut = '1;
            end else begin
                w_fracOut = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2Valid <= 1'b0;
            r_result  <= '0;
            r_flags   <= '0;
            r_s2Trap  <= 1'b0;
        end else if (w_s2Adv) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_result <= {r_s1Sign, w_expOut, w_fracOut};
                r_flags  <= {r_s1Ovf, r_s1Unf, r_s1Inv, r_s1Inx};
                r_s2Trap <= w_trap;
            end
        end
    end

    // A clear and a new set in the same cycle leave the new flags standing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sticky    <= '0;
            r_trapPulse <= 1'b0;
        end else begin
            r_sticky    <= (bus.flag_clear ? 4'b0000 : r_sticky) | (w_outXfer ? r_flags : 4'b0000);
            r_trapPulse <= w_outXfer & r_s2Trap;
        end
    end

    assign bus.in_ready     = w_s1Adv;
    assign bus.out_valid    = r_s2Valid;
    assign bus.result       = r_result;
    assign bus.out_flags    = r_flags;
    assign bus.sticky_flags = r_sticky;
    assign bus.trap_pulse   = r_trapPulse;

endmodule

// File: tb/tb_fp_final_pipe.sv
// Bench for fp_final_pipe: directed vectors with literal expectations plus a
// queue-based reference model checked against every output transfer.
module tb_fp_final_pipe;

    localparam int WEXP  = 8;
    localparam int WFRAC = 23;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fp_final_pipe_if #(.WEXP(WEXP), .WFRAC(WFRAC)) bus ();

    fp_final_pipe #(.WEXP(WEXP), .WFRAC(WFRAC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [22:0] aFrac;
        logic [22:0] bFrac;
        logic        sa, sb, abig, ainf, binf, anan, bnan, asignan, bsignan;
        logic        denorm, inex, expneg;
        logic [8:0]  exp;
        logic        effop, op, zero;
        logic [22:0] roundsum;
        logic [1:0]  rmode;
        logic        overtrap, undertrap;
    } beat_t;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  flags;
        logic        trap;
    } expect_t;

    int         checks    = 0;
    int         failures  = 0;
    int         popCount  = 0;
    expect_t    expQ[$];
    logic [3:0] stickyExp = 4'b0000;
    logic       trapExp   = 1'b0;
    bit         armed     = 1'b0;
    bit         prevStall = 1'b0;
    logic [31:0] prevResult;
    logic [3:0]  prevFlags;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    function automatic beat_t blankBeat();
        beat_t b;
        b = '{default: '0};
        b.abig = 1'b1;
        return b;
    endfunction

    // Reference model: IEEE-style classification in plain arithmetic.
    function automatic expect_t modelBeat(input beat_t b);
        expect_t     r;
        bit          special, ovf, unf, inv, inx, sign, clamp;
        int          e, lowExp;
        logic [22:0] f;
        special = b.ainf || b.binf || b.anan || b.bnan;
        ovf     = (b.exp >= 9'd255) && !b.expneg && !special && !b.zero;
        unf     = b.expneg && (b.inex || b.undertrap);
        inv     = (b.ainf && b.binf && b.effop) || b.asignan || b.bsignan;
        inx     = !special && (b.inex || (ovf && !b.overtrap));
        if (b.zero) sign = (b.sa && b.sb && !b.op) || (b.rmode == 2'd3 && b.sa != b.sb);
        else        sign = b.abig ? b.sa : (b.sb ^ b.op);
        clamp  = ovf && (b.rmode == 2'd1 || (b.rmode == 2'd2 && sign) || (b.rmode == 2'd3 && !sign));
        lowExp = int'(b.exp[7:0]);
        if (ovf && b.overtrap)                      e = (lowExp + 256 - 192) % 256;
        else if ((unf || b.denorm) && b.undertrap)  e = (lowExp + 192) % 256;
        else if (special || ovf || unf || b.zero || b.denorm)
            e = ((unf || b.zero || b.denorm) && !inv) ? 0 : (clamp ? 254 : 255);
        else                                        e = lowExp;
        if (special || ovf || unf || inv) begin
            if (b.anan || b.bnan || inv) f = 23'h400000 | ((b.anan ? b.aFrac : b.bFrac) & 23'h3FFFFF);
            else if (clamp)             f = 23'h7FFFFF;
            else                        f = 23'h000000;
        end else begin
            f = b.roundsum;
        end
        r.result = {sign, 8'(e), f};
        r.flags  = {ovf, unf, inv, inx};
        r.trap   = (ovf && b.overtrap) || (unf && b.undertrap) || inv;
        return r;
    endfunction

    function automatic beat_t sampleBus();
        beat_t b;
        b.aFrac = bus.a_frac;   b.bFrac = bus.b_frac;   b.sa = bus.sa;         b.sb = bus.sb;
        b.abig = bus.abig;      b.ainf = bus.ainf;      b.binf = bus.binf;     b.anan = bus.anan;
        b.bnan = bus.bnan;      b.asignan = bus.asignan; b.bsignan = bus.bsignan;
        b.denorm = bus.denorm;  b.inex = bus.inex;      b.expneg = bus.expneg; b.exp = bus.exp;
        b.effop = bus.effop;    b.op = bus.op;          b.zero = bus.zero;     b.roundsum = bus.roundsum;
        b.rmode = bus.rmode;    b.overtrap = bus.overtrap; b.undertrap = bus.undertrap;
        return b;
    endfunction

    task automatic applyStimulus(input beat_t b);
        bus.a_frac = b.aFrac;   bus.b_frac = b.bFrac;   bus.sa = b.sa;         bus.sb = b.sb;
        bus.abig = b.abig;      bus.ainf = b.ainf;      bus.binf = b.binf;     bus.anan = b.anan;
        bus.bnan = b.bnan;      bus.asignan = b.asignan; bus.bsignan = b.bsignan;
        bus.denorm = b.denorm;  bus.inex = b.inex;      bus.expneg = b.expneg; bus.exp = b.exp;
        bus.effop = b.effop;    bus.op = b.op;          bus.zero = b.zero;     bus.roundsum = b.roundsum;
        bus.rmode = b.rmode;    bus.overtrap = b.overtrap; bus.undertrap = b.undertrap;
        bus.in_valid = 1'b1;
    endtask

    task automatic waitOutput(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 8);
        if (!bus.out_valid) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout: out_valid got 0, expected 1 within 8 cycles", name);
        end
    endtask

    // One beat through an idle pipe, pinned against literal result, flags and trap.
    task automatic runLiteral(input string name, input beat_t b, input logic [31:0] wantRes,
                              input logic [3:0] wantFlags, input logic wantTrap);
        expect_t m;
        m = modelBeat(b);
        checkOutput({name, "_model"}, m.result, wantRes);
        applyStimulus(b);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        waitOutput(name);
        checkOutput({name, "_result"}, bus.result, wantRes);
        checkOutput({name, "_flags"}, 32'(bus.out_flags), 32'(wantFlags));
        @(posedge clk);
        @(negedge clk);
        checkOutput({name, "_trap"}, 32'(bus.trap_pulse), 32'(wantTrap));
        @(posedge clk); #1;
    endtask

    // Compare process: scoreboard on transfers, sticky/trap model, hold-while-stalled.
    initial begin : monitor
        expect_t    e;
        logic [3:0] newFlags;
        logic       trapNext;
        forever begin
            @(negedge clk);
            if (armed) begin
                checkOutput("sticky_flags", 32'(bus.sticky_flags), 32'(stickyExp));
                checkOutput("trap_pulse", 32'(bus.trap_pulse), 32'(trapExp));
                if (prevStall) begin
                    checkOutput("hold_result", bus.result, prevResult);
                    checkOutput("hold_flags", 32'(bus.out_flags), 32'(prevFlags));
                end
            end
            if (!rst_n) begin
                expQ.delete();
                stickyExp = 4'b0000;
                trapExp   = 1'b0;
                prevStall = 1'b0;
                armed     = 1'b1;
            end else if (armed) begin
                newFlags = 4'b0000;
                trapNext = 1'b0;
                if (bus.out_valid && bus.out_ready) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL sb_unexpected: got result 0x%0h, expected no output", bus.result);
                    end else begin
                        e = expQ.pop_front();
                        popCount++;
                        checkOutput("sb_result", bus.result, e.result);
                        checkOutput("sb_flags", 32'(bus.out_flags), 32'(e.flags));
                        newFlags = e.flags;
                        trapNext = e.trap;
                    end
                end
                stickyExp  = (bus.flag_clear ? 4'b0000 : stickyExp) | newFlags;
                trapExp    = trapNext;
                prevStall  = bus.out_valid && !bus.out_ready;
                prevResult = bus.result;
                prevFlags  = bus.out_flags;
                if (bus.in_valid && bus.in_ready) expQ.push_back(modelBeat(sampleBus()));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at 200000, expected to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        beat_t b;
        int    k, cyc, pop0;
        logic  acc;
        applyStimulus(blankBeat());
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        bus.flag_clear = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_result", bus.result, 32'd0);
        checkOutput("reset_out_flags", 32'(bus.out_flags), 32'd0);
        checkOutput("reset_sticky", 32'(bus.sticky_flags), 32'd0);
        checkOutput("reset_trap", 32'(bus.trap_pulse), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("[TB] normal add and two-cycle latency");
        b = blankBeat(); b.exp = 9'h080; b.roundsum = 23'h400000;
        applyStimulus(b);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("t1_valid_after_1", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        checkOutput("t1_valid_after_2", 32'(bus.out_valid), 32'd1);
        checkOutput("t1_result", bus.result, 32'h40400000);
        checkOutput("t1_flags", 32'(bus.out_flags), 32'd0);
        @(posedge clk); #1;

        $display("[TB] overflow, rounding modes, traps, specials");
        b = blankBeat(); b.exp = 9'h0FF;
        runLiteral("ovf_rne", b, 32'h7F800000, 4'b1001, 1'b0);
        b.rmode = 2'd1;
        runLiteral("ovf_rz", b, 32'h7F7FFFFF, 4'b1001, 1'b0);
        b.rmode = 2'd3;
        runLiteral("ovf_rm_pos", b, 32'h7F7FFFFF, 4'b1001, 1'b0);
        b.rmode = 2'd2;
        runLiteral("ovf_rp_pos", b, 32'h7F800000, 4'b1001, 1'b0);
        b.sa = 1'b1; b.sb = 1'b1;
        runLiteral("ovf_rp_neg", b, 32'hFF7FFFFF, 4'b1001, 1'b0);

        b = blankBeat(); b.exp = 9'h100; b.overtrap = 1'b1;
        runLiteral("ovf_trap", b, 32'h20000000, 4'b1000, 1'b1);

        b = blankBeat(); b.ainf = 1'b1; b.binf = 1'b1; b.effop = 1'b1;
        runLiteral("inf_minus_inf", b, 32'h7FC00000, 4'b0010, 1'b1);

        b = blankBeat(); b.zero = 1'b1; b.sb = 1'b1; b.rmode = 2'd3;
        runLiteral("zero_rm", b, 32'h80000000, 4'b0000, 1'b0);
        b.rmode = 2'd0;
        runLiteral("zero_rne", b, 32'h00000000, 4'b0000, 1'b0);

        b = blankBeat(); b.expneg = 1'b1; b.inex = 1'b1; b.exp = 9'h1F0;
        runLiteral("unf_plain", b, 32'h00000000, 4'b0101, 1'b0);
        b = blankBeat(); b.expneg = 1'b1; b.undertrap = 1'b1; b.exp = 9'h010;
        runLiteral("unf_trap", b, 32'h68000000, 4'b0100, 1'b1);

        b = blankBeat(); b.anan = 1'b1; b.asignan = 1'b1; b.aFrac = 23'h000123; b.sa = 1'b1;
        runLiteral("snan_a", b, 32'hFFC00123, 4'b0010, 1'b1);

        b = blankBeat(); b.denorm = 1'b1; b.roundsum = 23'h012345;
        runLiteral("denorm", b, 32'h00012345, 4'b0000, 1'b0);

        b = blankBeat(); b.abig = 1'b0; b.op = 1'b1; b.exp = 9'h085; b.roundsum = 23'h123456; b.inex = 1'b1;
        runLiteral("sub_b_larger", b, 32'hC2923456, 4'b0001, 1'b0);

        $display("[TB] backpressure stream");
        pop0 = popCount;
        k = 0;
        cyc = 0;
        bus.out_ready = 1'b0;
        while (k < 5 && cyc < 40) begin
            b = blankBeat(); b.exp = 9'(128 + k); b.roundsum = 23'(k * 69905 + 1);
            applyStimulus(b);
            @(negedge clk);
            acc = bus.in_ready;
            if (cyc == 2) begin
                checkOutput("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
                checkOutput("bp_accepted_before_full", 32'(k), 32'd2);
            end
            @(posedge clk); #1;
            if (acc) k++;
            cyc++;
            if (cyc == 4) bus.out_ready = 1'b1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clk);
        checkOutput("bp_beats_out", 32'(popCount - pop0), 32'd5);
        @(posedge clk); #1;

        $display("[TB] sticky clear coincident with overflow output");
        b = blankBeat(); b.exp = 9'h100; b.overtrap = 1'b1;
        applyStimulus(b);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        bus.flag_clear = 1'b1;
        @(posedge clk); #1;
        bus.flag_clear = 1'b0;
        @(negedge clk);
        checkOutput("clear_with_set", 32'(bus.sticky_flags), 32'b1000);
        @(posedge clk); #1;

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 3; i++) begin
            b = blankBeat(); b.exp = 9'(100 + i); b.roundsum = 23'(i + 7);
            applyStimulus(b);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_result", bus.result, 32'd0);
        checkOutput("rst_sticky", 32'(bus.sticky_flags), 32'd0);
        @(negedge clk);
        checkOutput("rst_pipe_empty", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        checkOutput("sb_drained", 32'(expQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
